// File: rtl/onehot_scan_decoder.sv
// Binary-to-one-hot decoder with a prescaled up/down scan mode; all outputs registered (latency 1).
// No backpressure: en=0 freezes all state and suppresses the out_valid/wrap pulses.
module onehot_scan_decoder #(
  parameter  int SEL_W = 4,
  parameter  int DIV_W = 8,
  localparam int OUT_W = 2**SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             in_valid,
  input  logic [SEL_W-1:0] binary,
  input  logic             dir,
  input  logic [DIV_W-1:0] div,
  output logic [OUT_W-1:0] onehot,
  output logic [SEL_W-1:0] index,
  output logic             out_valid,
  output logic             wrap
);

  localparam logic [OUT_W-1:0] one_bit   = {{(OUT_W-1){1'b0}}, 1'b1};
  localparam logic [SEL_W-1:0] index_max = {SEL_W{1'b1}};

  logic [DIV_W-1:0] cnt;
  logic             mode_q;
  logic [SEL_W-1:0] base;
  logic [SEL_W-1:0] next_index;
  logic             step_wraps;

  // An all-zero onehot (fresh out of reset) scans as if it sat at index 0.
  always_comb begin
    base       = (onehot == '0) ? '0 : index;
    next_index = dir ? (base - SEL_W'(1)) : (base + SEL_W'(1));
    step_wraps = dir ? (base == '0) : (base == index_max);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      onehot    <= '0;
      index     <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
      cnt       <= '0;
      mode_q    <= mode;
    end else if (!en) begin
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else if (mode != mode_q) begin
      // Mode switch cycle only restarts the prescaler; the output is held.
      mode_q    <= mode;
      cnt       <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else if (!mode) begin
      wrap      <= 1'b0;
      out_valid <= in_valid;
      if (in_valid) begin
        index  <= binary;
        onehot <= one_bit << binary;
      end
    end else if (cnt >= div) begin
      cnt       <= '0;
      index     <= next_index;
      onehot    <= one_bit << next_index;
      out_valid <= 1'b1;
      wrap      <= step_wraps;
    end else begin
      cnt       <= cnt + DIV_W'(1);
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Directed bench for onehot_scan_decoder: each step queues its expected outputs, which are checked one cycle later.
module tb_onehot_scan_decoder;

  localparam int SEL_W = 4;
  localparam int DIV_W = 8;
  localparam int OUT_W = 16;

  typedef struct {
    logic [OUT_W-1:0] oh;
    logic [SEL_W-1:0] idx;
    logic             ov;
    logic             wr;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             mode;
  logic             in_valid;
  logic [SEL_W-1:0] binary;
  logic             dir;
  logic [DIV_W-1:0] div;
  logic [OUT_W-1:0] onehot;
  logic [SEL_W-1:0] index;
  logic             out_valid;
  logic             wrap;

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   step_no   = 0;
  int   cur_idx   = 0;
  bit   cur_zero  = 1'b1;
  exp_t sb[$];

  onehot_scan_decoder #(.SEL_W(SEL_W), .DIV_W(DIV_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .in_valid  (in_valid),
    .binary    (binary),
    .dir       (dir),
    .div       (div),
    .onehot    (onehot),
    .index     (index),
    .out_valid (out_valid),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s step=%0d observed=%h expected=%h", tag, step_no, obs, exp);
  endtask

  // Queue the outputs expected after the coming edge, clock once, then check them.
  task automatic tick(input int idx, input bit zero, input bit ov, input bit wr);
    exp_t e;
    e.oh  = zero ? '0 : (16'h0001 << idx);
    e.idx = SEL_W'(idx);
    e.ov  = ov;
    e.wr  = wr;
    sb.push_back(e);
    cur_idx  = idx;
    cur_zero = zero;
    @(posedge clk);
    #1;
    step_no++;
    if (sb.size() == 0) begin
      total_cnt++;
      $error("FAIL scoreboard step=%0d observed=empty expected=entry", step_no);
    end else begin
      e = sb.pop_front();
      check("onehot",    onehot,           e.oh);
      check("index",     16'(index),       16'(e.idx));
      check("out_valid", 16'(out_valid),   16'(e.ov));
      check("wrap",      16'(wrap),        16'(e.wr));
    end
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick(cur_idx, cur_zero, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode = 1'b0; in_valid = 1'b0;
    binary = '0; dir = 1'b0; div = '0;

    tick(0, 1, 0, 0);
    rst = 1'b0;
    tick(0, 1, 0, 0);

    // Back-to-back decode of every index
    in_valid = 1'b1;
    for (int i = 0; i < OUT_W; i++) begin
      binary = SEL_W'(i);
      tick(i, 0, 1, 0);
    end
    in_valid = 1'b0;
    tick(15, 0, 0, 0);

    // en=0 beats in_valid
    en = 1'b0; in_valid = 1'b1; binary = 4'd3;
    tick(15, 0, 0, 0);
    en = 1'b1;

    // Decode 9, then switch to scan up div=1; scan ignores in_valid/binary
    binary = 4'd9;
    tick(9, 0, 1, 0);
    mode = 1'b1; div = 8'd1; binary = 4'd2;
    tick(9, 0, 0, 0);
    hold(1);
    tick(10, 0, 1, 0);

    // div=0 steps every cycle, wrapping up through 15 -> 0
    div = 8'd0;
    for (int k = 11; k <= 16; k++) tick(k % 16, 0, 1, k == 16);
    tick(1, 0, 1, 0);

    // Scan down from 1: 0 without wrap, then 15 with wrap
    dir = 1'b1;
    tick(0, 0, 1, 0);
    tick(15, 0, 1, 1);
    tick(14, 0, 1, 0);

    // div=5 with a 10-cycle freeze at cnt=3
    div = 8'd5; dir = 1'b0;
    hold(3);
    en = 1'b0;
    hold(10);
    en = 1'b1;
    hold(2);
    tick(15, 0, 1, 0);

    // div lowered below the running count steps at once
    hold(3);
    div = 8'd1;
    tick(0, 0, 1, 1);

    // Mode toggles clear the prescaler and hold the output
    div = 8'd2;
    hold(2);
    mode = 1'b0;
    hold(1);
    mode = 1'b1;
    hold(1);
    hold(2);
    tick(1, 0, 1, 0);

    // Reset mid-count restarts scanning from the all-zero rule
    div = 8'd3;
    hold(1);
    rst = 1'b1;
    tick(0, 1, 0, 0);
    rst = 1'b0;
    hold(3);
    tick(1, 0, 1, 0);

    // Full scan up from reset with div=2
    div = 8'd2;
    rst = 1'b1;
    tick(0, 1, 0, 0);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      hold(2);
      tick(k % 16, 0, 1, k == 16);
    end

    // Decode 15 -> 0 never raises wrap
    mode = 1'b0;
    tick(0, 0, 0, 0);
    binary = 4'd15;
    tick(15, 0, 1, 0);
    binary = 4'd0;
    tick(0, 0, 1, 0);

    // Reset overrides en=0
    en = 1'b0; rst = 1'b1;
    tick(0, 1, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
